// File: rtl/sterownik_fir.sv
// sterownik_fir: control-only sequencer for the FIR datapath (coef load, sample-buffer clear, N-cycle MAC pass).
// Define STEROWNIK_STAT_EN to add the saturating licz_wynikow consumed-result counter.
module sterownik_fir #(
  parameter int N_MAX = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_cfg,
  input  logic [5:0]    liczba_wsp,
  input  logic          wsp_valid,
  output logic          wsp_ready,
  output logic          wsp_we,
  output logic [AW-1:0] wsp_adres,
  input  logic          probka_valid,
  output logic          probka_ready,
  output logic          probka_we,
  output logic          probka_zero,
  output logic [AW-1:0] probka_adres,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          wynik_valid,
  input  logic          wynik_ready,
  output logic          busy,
`ifdef STEROWNIK_STAT_EN
  output logic [15:0]   licz_wynikow,
`endif
  output logic          cfg_err
);

  typedef enum logic [2:0] {IDLE, CFG, CLR, WAIT, MAC, DRAIN, OUT} stan_t;

  localparam logic [5:0] N_MAX_W = 6'(N_MAX);

  stan_t         stan;
  logic [AW-1:0] n_last;
  logic [AW-1:0] k;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] i;
  logic [AW-1:0] rd_ptr;
  logic          cfg_ok;
  logic          cfg_start;
  logic          sample_acc;
  logic          wynik_hs;

  assign cfg_ok       = (liczba_wsp != 6'd0) && (liczba_wsp <= N_MAX_W);
  assign cfg_start    = start_cfg && ((stan == IDLE) || (stan == WAIT));
  // start_cfg takes priority over a sample offered in the same cycle
  assign probka_ready = (stan == WAIT) && !start_cfg;
  assign sample_acc   = probka_ready && probka_valid;
  assign wynik_valid  = (stan == OUT);
  assign wynik_hs     = wynik_valid && wynik_ready;
  assign wsp_ready    = (stan == CFG);
  assign wsp_we       = wsp_ready && wsp_valid;
  assign probka_zero  = (stan == CLR);
  assign probka_we    = probka_zero || sample_acc;
  assign busy         = !((stan == IDLE) || (stan == WAIT));

  always_comb begin
    wsp_adres    = '0;
    probka_adres = '0;
    case (stan)
      CFG:  wsp_adres = k;
      CLR:  probka_adres = k;
      WAIT: probka_adres = wr_ptr;
      MAC: begin
        wsp_adres    = i;
        probka_adres = rd_ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stan    <= IDLE;
      n_last  <= '0;
      k       <= '0;
      wr_ptr  <= '0;
      i       <= '0;
      rd_ptr  <= '0;
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      // RAM read latency is one cycle, so MAC strobes trail the address phase by one
      mac_en  <= (stan == MAC);
      mac_clr <= (stan == MAC) && (i == '0);
      case (stan)
        IDLE, WAIT: begin
          if (start_cfg) begin
            if (cfg_ok) begin
              n_last <= AW'(liczba_wsp - 6'd1);
              k      <= '0;
              stan   <= CFG;
            end else begin
              cfg_err <= 1'b1;
              stan    <= IDLE;
            end
          end else if (sample_acc) begin
            i      <= '0;
            rd_ptr <= wr_ptr;
            stan   <= MAC;
          end
        end
        CFG: begin
          if (wsp_valid) begin
            if (k == n_last) begin
              k    <= '0;
              stan <= CLR;
            end else begin
              k <= k + AW'(1);
            end
          end
        end
        CLR: begin
          if (k == n_last) begin
            k      <= '0;
            wr_ptr <= '0;
            stan   <= WAIT;
          end else begin
            k <= k + AW'(1);
          end
        end
        MAC: begin
          // sample read pointer walks backwards through the circular buffer, wrapping at N
          rd_ptr <= (rd_ptr == '0) ? n_last : rd_ptr - AW'(1);
          if (i == n_last) begin
            stan <= DRAIN;
          end else begin
            i <= i + AW'(1);
          end
        end
        DRAIN: begin
          wr_ptr <= (wr_ptr == n_last) ? '0 : wr_ptr + AW'(1);
          stan   <= OUT;
        end
        OUT: begin
          if (wynik_ready) stan <= WAIT;
        end
        default: stan <= IDLE;
      endcase
    end
  end

`ifdef STEROWNIK_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      licz_wynikow <= '0;
    end else if (cfg_start && cfg_ok) begin
      licz_wynikow <= '0;
    end else if (wynik_hs && (licz_wynikow != 16'hFFFF)) begin
      licz_wynikow <= licz_wynikow + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sterownik_fir.sv
// Self-checking bench for sterownik_fir; per-cycle MAC expectations are queued at sample acceptance.
module tb_sterownik_fir;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_cfg;
  logic [5:0] liczba_wsp;
  logic       wsp_valid;
  logic       wsp_ready;
  logic       wsp_we;
  logic [4:0] wsp_adres;
  logic       probka_valid;
  logic       probka_ready;
  logic       probka_we;
  logic       probka_zero;
  logic [4:0] probka_adres;
  logic       mac_clr;
  logic       mac_en;
  logic       wynik_valid;
  logic       wynik_ready;
  logic       busy;
  logic       cfg_err;
`ifdef STEROWNIK_STAT_EN
  logic [15:0] licz_wynikow;
`endif

  sterownik_fir #(.N_MAX(32), .AW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_cfg    (start_cfg),
    .liczba_wsp   (liczba_wsp),
    .wsp_valid    (wsp_valid),
    .wsp_ready    (wsp_ready),
    .wsp_we       (wsp_we),
    .wsp_adres    (wsp_adres),
    .probka_valid (probka_valid),
    .probka_ready (probka_ready),
    .probka_we    (probka_we),
    .probka_zero  (probka_zero),
    .probka_adres (probka_adres),
    .mac_clr      (mac_clr),
    .mac_en       (mac_en),
    .wynik_valid  (wynik_valid),
    .wynik_ready  (wynik_ready),
    .busy         (busy),
`ifdef STEROWNIK_STAT_EN
    .licz_wynikow (licz_wynikow),
`endif
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       chk_adr;
    logic [4:0] wa;
    logic [4:0] pa;
    logic       clr;
    logic       en;
    logic       wv;
  } exp_t;

  exp_t q_exp[$];
  int   q_adr[$];
  int   checks = 0;
  int   errors = 0;
  int   m_n    = 0;
  int   m_wr   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_cfg = 0; liczba_wsp = 0; wsp_valid = 0; probka_valid = 0; wynik_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wsp_ready, wsp_we, probka_ready, probka_we, probka_zero, mac_clr, mac_en, wynik_valid, busy, cfg_err} !== 10'b0
        || wsp_adres !== 5'd0 || probka_adres !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ctl=%b wa=%0d pa=%0d, want all 0",
               {wsp_ready, wsp_we, probka_ready, probka_we, probka_zero, mac_clr, mac_en, wynik_valid, busy, cfg_err},
               wsp_adres, probka_adres);
    end
    rst_n = 1'b1;
    probka_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (probka_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: probka_ready=%b busy=%b, want 0 0", probka_ready, busy);
    end
    probka_valid = 1'b0;
  endtask

  task automatic test_cfg_err(input int val);
    step();
    start_cfg = 1'b1; liczba_wsp = 6'(val);
    @(negedge clk);
    step();
    start_cfg = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1 || wsp_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_pulse(%0d): cfg_err=%b wsp_ready=%b busy=%b, want 1 0 0", val, cfg_err, wsp_ready, busy);
    end
    step();
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0 || wsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_one_cycle(%0d): cfg_err=%b wsp_ready=%b, want 0 0", val, cfg_err, wsp_ready);
    end
  endtask

  // entered at posedge+1 of the first CFG cycle; leaves at the negedge of the first WAIT cycle
  task automatic cfg_body(input int n);
    int guard;
    int a;
    guard = 0;
    for (int j = 0; j < n; j++) q_adr.push_back(j);
    while (q_adr.size() > 0 && guard < 200) begin
      wsp_valid = (guard % 3 != 1);
      @(negedge clk);
      checks++;
      if (wsp_ready !== 1'b1 || wsp_we !== wsp_valid || busy !== 1'b1) begin
        errors++;
        $display("FAIL cfg_strobe: wsp_ready=%b wsp_we=%b busy=%b, want 1 %b 1", wsp_ready, wsp_we, busy, wsp_valid);
      end
      if (wsp_we === 1'b1 && q_adr.size() > 0) begin
        a = q_adr.pop_front();
        checks++;
        if (wsp_adres !== 5'(a)) begin
          errors++;
          $display("FAIL cfg_addr: wsp_adres=%0d, want %0d", wsp_adres, a);
        end
      end
      guard++;
      step();
    end
    wsp_valid = 1'b0;
    if (q_adr.size() > 0) begin
      checks++; errors++;
      $display("FAIL cfg_timeout: %0d coefficients not written", q_adr.size());
      q_adr.delete();
    end
    for (int j = 0; j < n; j++) q_adr.push_back(j);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      a = q_adr.pop_front();
      checks++;
      if (probka_we !== 1'b1 || probka_zero !== 1'b1 || probka_adres !== 5'(a) || wsp_we !== 1'b0) begin
        errors++;
        $display("FAIL clr_cycle: we=%b zero=%b adr=%0d wsp_we=%b, want 1 1 %0d 0", probka_we, probka_zero, probka_adres, wsp_we, a);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (probka_ready !== 1'b1 || busy !== 1'b0 || probka_zero !== 1'b0) begin
      errors++;
      $display("FAIL wait_entry: probka_ready=%b busy=%b zero=%b, want 1 0 0", probka_ready, busy, probka_zero);
    end
    m_n = n;
    m_wr = 0;
  endtask

  task automatic configure(input int n);
    step();
    start_cfg = 1'b1; liczba_wsp = 6'(n);
    @(negedge clk);
    step();
    start_cfg = 1'b0;
    cfg_body(n);
  endtask

  task automatic run_sample(input int hold);
    exp_t e;
    step();
    probka_valid = 1'b1;
    wynik_ready = (hold == 0);
    @(negedge clk);
    checks++;
    if (probka_ready !== 1'b1 || probka_we !== 1'b1 || probka_adres !== 5'(m_wr)) begin
      errors++;
      $display("FAIL accept: ready=%b we=%b adr=%0d, want 1 1 %0d", probka_ready, probka_we, probka_adres, m_wr);
    end
    for (int c = 1; c <= m_n + 2; c++) begin
      e.chk_adr = (c <= m_n);
      e.wa  = 5'(c - 1);
      e.pa  = 5'((m_wr - (c - 1) + m_n) % m_n);
      e.clr = (c == 2);
      e.en  = (c >= 2 && c <= m_n + 1);
      e.wv  = (c == m_n + 2);
      q_exp.push_back(e);
    end
    step();
    probka_valid = 1'b0;
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      @(negedge clk);
      checks++;
      if ({mac_clr, mac_en, wynik_valid, busy, probka_we} !== {e.clr, e.en, e.wv, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL mac_strobes(N=%0d): clr/en/wv/busy/we=%b, want %b", m_n,
                 {mac_clr, mac_en, wynik_valid, busy, probka_we}, {e.clr, e.en, e.wv, 1'b1, 1'b0});
      end
      if (e.chk_adr) begin
        checks++;
        if (wsp_adres !== e.wa || probka_adres !== e.pa) begin
          errors++;
          $display("FAIL mac_addr(N=%0d): wsp=%0d probka=%0d, want %0d %0d", m_n, wsp_adres, probka_adres, e.wa, e.pa);
        end
      end
      if (!e.wv) step();
    end
    for (int h = 0; h < hold; h++) begin
      step();
      @(negedge clk);
      checks++;
      if (wynik_valid !== 1'b1 || probka_ready !== 1'b0 || mac_en !== 1'b0) begin
        errors++;
        $display("FAIL backpressure: wynik_valid=%b probka_ready=%b mac_en=%b, want 1 0 0", wynik_valid, probka_ready, mac_en);
      end
    end
    wynik_ready = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (wynik_valid !== 1'b0 || probka_ready !== 1'b1) begin
      errors++;
      $display("FAIL result_release: wynik_valid=%b probka_ready=%b, want 0 1", wynik_valid, probka_ready);
    end
    m_wr = (m_wr + 1) % m_n;
  endtask

  task automatic test_start_priority();
    step();
    start_cfg = 1'b1; liczba_wsp = 6'd4; probka_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (probka_ready !== 1'b0 || probka_we !== 1'b0) begin
      errors++;
      $display("FAIL start_priority: probka_ready=%b probka_we=%b, want 0 0", probka_ready, probka_we);
    end
    step();
    start_cfg = 1'b0; probka_valid = 1'b0;
    cfg_body(4);
  endtask

  task automatic test_reset_mid_mac();
    step();
    probka_valid = 1'b1;
    step();
    probka_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wsp_ready, wsp_we, probka_ready, probka_we, probka_zero, mac_clr, mac_en, wynik_valid, busy, cfg_err} !== 10'b0
        || wsp_adres !== 5'd0 || probka_adres !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_mac: ctl=%b wa=%0d pa=%0d, want all 0",
               {wsp_ready, wsp_we, probka_ready, probka_we, probka_zero, mac_clr, mac_en, wynik_valid, busy, cfg_err},
               wsp_adres, probka_adres);
    end
    #7;
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      probka_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (probka_ready !== 1'b0 || busy !== 1'b0 || mac_en !== 1'b0) begin
        errors++;
        $display("FAIL unconfigured_after_reset: probka_ready=%b busy=%b mac_en=%b, want 0 0 0", probka_ready, busy, mac_en);
      end
    end
    probka_valid = 1'b0;
  endtask

`ifdef STEROWNIK_STAT_EN
  task automatic test_stat();
    configure(3);
    for (int j = 0; j < 3; j++) run_sample(0);
    checks++;
    if (licz_wynikow !== 16'd3) begin
      errors++;
      $display("FAIL stat_count: licz_wynikow=%0d, want 3", licz_wynikow);
    end
    configure(3);
    checks++;
    if (licz_wynikow !== 16'd0) begin
      errors++;
      $display("FAIL stat_clear: licz_wynikow=%0d, want 0", licz_wynikow);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cfg_err(0);
    test_cfg_err(33);
    configure(1);
    run_sample(0);
    run_sample(0);
    configure(4);
    run_sample(0);
    run_sample(0);
    run_sample(0);
    run_sample(5);
    run_sample(0);
    test_start_priority();
    run_sample(0);
    configure(3);
    for (int j = 0; j < 4; j++) run_sample(0);
    configure(32);
    run_sample(0);
    run_sample(2);
    test_reset_mid_mac();
    configure(4);
    run_sample(0);
`ifdef STEROWNIK_STAT_EN
    test_stat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
